hazard_unit: RTL and testbench
==============================

# hazard_unit

Pipeline hazard controller for the five-stage MIPS core. It sits beside the datapath, consuming its D/E/M/W register-address, write-enable, write-back-source, multiplier and cache-hit outputs. In return it drives the datapath's stall, flush and forwarding inputs. It also owns a multiplier-busy scoreboard and a stall-cycle performance counter.

## Interface
Parameters:
- CNT_W, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, synchronous and active-high.
- branchD  in  2  00 no branch, 01 beq, 10 bne, 11 treated as branch.
- RsD, RtD  in  5 each  source registers in Decode.
- RegWriteE, RegWriteM, RegWriteW  in  1 each  register-write enables per stage.
- WBSrcE, WBSrcM  in  4 each  write-back source; bit0 means load from data memory, bit2 means HI/LO move (mfhi/mflo).
- RsE, RtE, WriteRegE  in  5 each  Execute source and destination registers.
- WriteRegM, WriteRegW  in  5 each  Memory and Writeback destination registers.
- MultStartE, MultDoneE  in  1 each  multiplier launch (E) and result-ready strobes.
- hitM  in  1  data-cache hit for the access in Memory.
- stallF, stallD, stallE, stallM, stallW  out  1 each  hold the stage register.
- flushE  out  1  insert a bubble into E.
- forwardAD, forwardBD  out  1 each  Decode comparator operand from ALUMultOutM.
- forwardAE, forwardBE  out  2 each  00 register file, 01 resultW, 10 ALUMultOutM.
- mult_busy  out  1  multiplier operation outstanding.
- stall_cycles  out  CNT_W  count of cycles with stallF high.

## Operation
- Register $0 never matches in any comparison below.
- **forwardAE**:
  - 10 if RegWriteM and RsE==WriteRegM.
  - else 01 if RegWriteW and RsE==WriteRegW.
  - else 00.
  - forwardBE is the same using RtE.
- **forwardAD** = RegWriteM and RsD==WriteRegM. forwardBD is the same using RtD.
- **lwstall** = RegWriteE and WBSrcE[0] and WriteRegE in {RsD, RtD}.
- **brstall** requires branchD != 00, plus either of:
  - RegWriteE and WriteRegE in {RsD, RtD};
  - RegWriteM and WBSrcM[0] and WriteRegM in {RsD, RtD}.
- **misswait** = WBSrcM[0] and not hitM.
- **multwait** = mult_busy and WBSrcE[2] and not MultDoneE.
- **freeze** = misswait or multwait.
- Priority, highest first:
  1. rst: all stalls 0, flushE 0.
  2. freeze: stallF through stallW all 1, flushE 0.
  3. lwstall or brstall: stallF=stallD=1, flushE=1, stallE=stallM=stallW=0.
  4. Otherwise: all 0.
- Forwarding outputs are computed the same way in every case except rst, which forces them to 0.
- **mult_busy register** (in priority order):
  - rst sets it to 0.
  - MultStartE and not freeze sets it to 1. A start seen during freeze is ignored and is taken again once E advances.
  - MultDoneE clears it to 0.
  - Otherwise it holds.
  - If an accepted start and MultDoneE coincide, the result is 1.
- **stall_cycles**: rst sets it to 0; it increments by 1 on every cycle with stallF=1. It wraps from all-ones to 0 with no saturation.

## Timing
- Stall, flush and forward outputs are combinational from the current-cycle inputs, with zero latency.
- mult_busy and stall_cycles are registered and update on the clk rising edge.
- A cache miss holds all stages for exactly as many cycles as hitM stays low while WBSrcM[0]=1. Release happens in the first cycle hitM=1.
- An mflo/mfhi in E waits until the cycle MultDoneE=1; E advances in that same cycle.
- Load-use hazard: exactly one bubble.
- Branch in D after an ALU producer in E: one bubble.
- Branch in D after a load producer in E: two bubbles, lwstall then brstall.
- If rst asserts mid-freeze, outputs drop to 0 and mult_busy clears on the next edge.

## Test plan
- **ALU forwarding**:
  - WriteRegM=5, RegWriteM=1, RsE=5 -> forwardAE=10.
  - Same with RsE=0 -> forwardAE=00.
  - WriteRegW=7, RegWriteW=1, RtE=7, RegWriteM=0 -> forwardBE=01.
- **Load-use**: WBSrcE=0001, RegWriteE=1, WriteRegE=8, RsD=8 -> stallF=stallD=flushE=1 for one cycle. stall_cycles goes from 0 to 1.
- **Branch after load**: lw $9 then beq $9 -> two consecutive bubble cycles, then forwardAD=0 with the operand read from the register file.
- **Cache miss**: WBSrcM=0001, hitM=0 for 3 cycles -> all five stalls 1 and flushE 0 for exactly 3 cycles. stall_cycles advances by 3.
- **Multiplier scoreboard**:
  - MultStartE pulse, then WBSrcE=0100 with no MultDoneE for 4 cycles -> full freeze for 4 cycles and mult_busy=1.
  - On the MultDoneE cycle -> stalls 0; mult_busy reads 0 after the next edge.
- **Reset**: assert rst during a miss freeze with mult_busy=1 -> outputs 0 in the same cycle; mult_busy=0 and stall_cycles=0 after the edge.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit: stall/flush/forwarding control for the five-stage MIPS pipeline,
// plus the multiplier-busy scoreboard and a stall-cycle performance counter.
module hazard_unit #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       branchD,
   input  logic [4:0]       RsD,
   input  logic [4:0]       RtD,
   input  logic             RegWriteE,
   input  logic             RegWriteM,
   input  logic             RegWriteW,
   input  logic [3:0]       WBSrcE,
   input  logic [3:0]       WBSrcM,
   input  logic [4:0]       RsE,
   input  logic [4:0]       RtE,
   input  logic [4:0]       WriteRegE,
   input  logic [4:0]       WriteRegM,
   input  logic [4:0]       WriteRegW,
   input  logic             MultStartE,
   input  logic             MultDoneE,
   input  logic             hitM,
   output logic             stallF,
   output logic             stallD,
   output logic             stallE,
   output logic             stallM,
   output logic             stallW,
   output logic             flushE,
   output logic             forwardAD,
   output logic             forwardBD,
   output logic [1:0]       forwardAE,
   output logic [1:0]       forwardBE,
   output logic             mult_busy,
   output logic [CNT_W-1:0] stall_cycles
);

   logic             mult_busy_q, mult_busy_d;
   logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

   logic lwstall, brstall, misswait, multwait, freeze;
   logic e_hits_d, m_hits_d;

   // Only bit0 (load) and bit2 (HI/LO move) of the write-back source matter here.
   logic unused_wbsrc;
   assign unused_wbsrc = ^{WBSrcE[3], WBSrcE[1], WBSrcM[3:1]};

   // Register $0 is hardwired to zero, so it never creates a dependency.
   function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
      return (a != 5'd0) && (a == b);
   endfunction

   // Hazard conditions derived from the current pipeline contents.
   always_comb begin
      // NOTE: every variable gets a value on every path of a combinational block; a missed
      // branch would make synthesis infer a latch to hold the old value.
      e_hits_d = reg_match(WriteRegE, RsD) || reg_match(WriteRegE, RtD);
      m_hits_d = reg_match(WriteRegM, RsD) || reg_match(WriteRegM, RtD);
      lwstall  = RegWriteE && WBSrcE[0] && e_hits_d;
      brstall  = (branchD != 2'b00) &&
                 ((RegWriteE && e_hits_d) || (RegWriteM && WBSrcM[0] && m_hits_d));
      misswait = WBSrcM[0] && !hitM;
      multwait = mult_busy_q && WBSrcE[2] && !MultDoneE;
      freeze   = misswait || multwait;
   end

   // Stall/flush priority and forwarding selects; reset forces everything low.
   always_comb begin
      stallF    = 1'b0;
      stallD    = 1'b0;
      stallE    = 1'b0;
      stallM    = 1'b0;
      stallW    = 1'b0;
      flushE    = 1'b0;
      forwardAD = 1'b0;
      forwardBD = 1'b0;
      forwardAE = 2'b00;
      forwardBE = 2'b00;
      if (!rst) begin
         if (freeze) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            stallW = 1'b1;
         end else if (lwstall || brstall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
         end

         // Memory-stage result is newer than writeback, so it takes precedence.
         if (RegWriteM && reg_match(RsE, WriteRegM))      forwardAE = 2'b10;
         else if (RegWriteW && reg_match(RsE, WriteRegW)) forwardAE = 2'b01;
         if (RegWriteM && reg_match(RtE, WriteRegM))      forwardBE = 2'b10;
         else if (RegWriteW && reg_match(RtE, WriteRegW)) forwardBE = 2'b01;

         forwardAD = RegWriteM && reg_match(RsD, WriteRegM);
         forwardBD = RegWriteM && reg_match(RtD, WriteRegM);
      end
   end

   // Next-state for the multiplier scoreboard and the stall counter.
   always_comb begin
      mult_busy_d = mult_busy_q;
      // A start while frozen is not accepted; the instruction re-presents it once E moves.
      if (MultStartE && !freeze) mult_busy_d = 1'b1;
      else if (MultDoneE)        mult_busy_d = 1'b0;
      stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, stallF};
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // pre-edge values regardless of statement order.
      if (rst) begin
         mult_busy_q    <= 1'b0;
         stall_cycles_q <= '0;
      end else begin
         mult_busy_q    <= mult_busy_d;
         stall_cycles_q <= stall_cycles_d;
      end
   end

   assign mult_busy    = mult_busy_q;
   assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed stimulus with a scoreboard queue of expected outputs.
module tb_hazard_unit;

   localparam int CNT_W = 3;  // narrow counter so the wrap-around is exercised

   localparam logic [11:0] NONE   = 12'h000;
   localparam logic [11:0] BUBBLE = 12'hC40;  // stallF, stallD, flushE
   localparam logic [11:0] FREEZE = 12'hF80;  // stallF..stallW

   typedef enum int { K_COMB, K_BUSY, K_CNT } kind_e;
   typedef struct {
      string       tag;
      kind_e       kind;
      logic [11:0] exp;
   } exp_t;

   logic             clk, rst;
   logic [1:0]       branchD;
   logic [4:0]       RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic             RegWriteE, RegWriteM, RegWriteW;
   logic [3:0]       WBSrcE, WBSrcM;
   logic             MultStartE, MultDoneE, hitM;
   logic             stallF, stallD, stallE, stallM, stallW, flushE;
   logic             forwardAD, forwardBD;
   logic [1:0]       forwardAE, forwardBE;
   logic             mult_busy;
   logic [CNT_W-1:0] stall_cycles;

   exp_t             sb[$];
   logic [CNT_W-1:0] exp_cnt;
   int               n_checks = 0;
   int               n_fail   = 0;

   hazard_unit #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .branchD(branchD), .RsD(RsD), .RtD(RtD),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .WBSrcE(WBSrcE), .WBSrcM(WBSrcM), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .MultStartE(MultStartE), .MultDoneE(MultDoneE), .hitM(hitM),
      .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM),
      .stallW(stallW), .flushE(flushE), .forwardAD(forwardAD), .forwardBD(forwardBD),
      .forwardAE(forwardAE), .forwardBE(forwardBE), .mult_busy(mult_busy),
      .stall_cycles(stall_cycles)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [11:0] observe(input kind_e k);
      case (k)
         K_COMB:  return {stallF, stallD, stallE, stallM, stallW, flushE,
                          forwardAD, forwardBD, forwardAE, forwardBE};
         K_BUSY:  return {11'b0, mult_busy};
         default: return {{(12-CNT_W){1'b0}}, stall_cycles};
      endcase
   endfunction

   // Pop every pending expectation and compare it against the DUT.
   task automatic drain();
      exp_t        e;
      logic [11:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = observe(e.kind);
         n_checks++;
         assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
         end
      end
   endtask

   // One clock: check combinational outputs mid-cycle, registered outputs after the edge.
   task automatic cycle(input string tag, input logic [11:0] exp_comb, input logic exp_busy);
      sb.push_back('{tag, K_COMB, exp_comb});
      @(negedge clk);
      drain();
      if (rst)              exp_cnt = '0;
      else if (exp_comb[11]) exp_cnt = exp_cnt + 1'b1;
      @(posedge clk);
      #1;
      sb.push_back('{{tag, "/busy"}, K_BUSY, {11'b0, exp_busy}});
      sb.push_back('{{tag, "/cnt"}, K_CNT, {{(12-CNT_W){1'b0}}, exp_cnt}});
      drain();
   endtask

   task automatic idle();
      branchD = 2'b00; RsD = 0; RtD = 0; RsE = 0; RtE = 0;
      WriteRegE = 0; WriteRegM = 0; WriteRegW = 0;
      RegWriteE = 0; RegWriteM = 0; RegWriteW = 0;
      WBSrcE = 4'b0000; WBSrcM = 4'b0000;
      MultStartE = 0; MultDoneE = 0; hitM = 1'b1;
   endtask

   initial begin
      exp_cnt = '0;
      idle();
      // Reset with live hazards on the inputs: everything must read zero.
      rst = 1'b1;
      RegWriteM = 1; WriteRegM = 5; RsE = 5; WBSrcM = 4'b0001; hitM = 0;
      cycle("reset_busy_inputs", NONE, 1'b0);
      cycle("reset_hold", NONE, 1'b0);
      rst = 1'b0;
      idle();
      cycle("idle", NONE, 1'b0);

      // ALU forwarding.
      RegWriteM = 1; WriteRegM = 5; RsE = 5;
      cycle("fwdAE_mem", 12'h008, 1'b0);
      RsE = 0;
      cycle("fwdAE_rs0_nomatch", NONE, 1'b0);
      WriteRegM = 0;
      cycle("fwdAE_zero_reg", NONE, 1'b0);
      idle(); RegWriteW = 1; WriteRegW = 7; RtE = 7;
      cycle("fwdBE_wb", 12'h001, 1'b0);
      RegWriteM = 1; WriteRegM = 7; RsE = 7;
      cycle("fwd_mem_over_wb", 12'h00A, 1'b0);
      idle(); RegWriteM = 1; WriteRegM = 3; RsD = 3; RtD = 3;
      cycle("fwdAD_BD", 12'h030, 1'b0);

      // Load-use: exactly one bubble, then the load forwards from M.
      idle(); RegWriteE = 1; WBSrcE = 4'b0001; WriteRegE = 8; RsD = 8;
      cycle("loaduse_bubble", BUBBLE, 1'b0);
      idle(); RegWriteM = 1; WBSrcM = 4'b0001; WriteRegM = 8; RsE = 8;
      cycle("loaduse_release", 12'h008, 1'b0);

      // Branch after load: lwstall, then brstall, then release.
      idle(); RegWriteE = 1; WBSrcE = 4'b0001; WriteRegE = 9; RsD = 9; branchD = 2'b01;
      cycle("brload_bubble1", BUBBLE, 1'b0);
      idle(); RegWriteM = 1; WBSrcM = 4'b0001; WriteRegM = 9; RsD = 9; branchD = 2'b01;
      cycle("brload_bubble2", BUBBLE | 12'h020, 1'b0);
      idle(); RegWriteW = 1; WriteRegW = 9; RsD = 9; branchD = 2'b01;
      cycle("brload_release", NONE, 1'b0);

      // Branch after ALU producer: one bubble; branchD=11 also counts as a branch.
      idle(); RegWriteE = 1; WriteRegE = 4; RtD = 4; branchD = 2'b10;
      cycle("bralu_bne", BUBBLE, 1'b0);
      branchD = 2'b11;
      cycle("bralu_code11", BUBBLE, 1'b0);
      branchD = 2'b00;
      cycle("alu_no_branch", NONE, 1'b0);

      // Cache miss for three cycles; a multiply start during freeze is ignored.
      idle(); WBSrcM = 4'b0001; hitM = 0;
      cycle("miss1", FREEZE, 1'b0);
      MultStartE = 1;
      cycle("miss2_start_ignored", FREEZE, 1'b0);
      MultStartE = 0;
      cycle("miss3", FREEZE, 1'b0);
      hitM = 1;
      cycle("miss_release", NONE, 1'b0);

      // Multiplier scoreboard: mflo waits four cycles, released on MultDoneE.
      idle(); MultStartE = 1;
      cycle("mult_start", NONE, 1'b1);
      idle(); RegWriteE = 1; WBSrcE = 4'b0100; WriteRegE = 10;
      for (int i = 0; i < 4; i++) cycle("mult_wait", FREEZE, 1'b1);
      MultDoneE = 1;
      cycle("mult_done", NONE, 1'b0);
      MultDoneE = 0;
      cycle("mflo_not_busy", NONE, 1'b0);

      // Accepted start coinciding with done leaves the scoreboard set.
      idle(); MultStartE = 1;
      cycle("mult_start2", NONE, 1'b1);
      MultDoneE = 1;
      cycle("start_and_done", NONE, 1'b1);
      MultStartE = 0;
      cycle("done_clears", NONE, 1'b0);

      // Reset in the middle of a miss freeze with the multiplier busy.
      idle(); MultStartE = 1;
      cycle("mult_start3", NONE, 1'b1);
      idle(); WBSrcM = 4'b0001; hitM = 0;
      cycle("freeze_before_reset", FREEZE, 1'b1);
      rst = 1'b1;
      cycle("reset_mid_freeze", NONE, 1'b0);
      rst = 1'b0;
      idle();
      cycle("after_reset", NONE, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
